instr_mem_loadable: RTL

//  Parametrised, synchronous instruction memory for the single-cycle/pipelined core fetch stage.

---
 rtl/instr_mem_pkg.sv | 22 ++
 rtl/instr_mem_bank.sv | 28 ++
 rtl/instr_mem_loadable.sv | 138 +++++++++++++
 3 files changed

// File: rtl/instr_mem_pkg.sv
// Shared types and helpers for the loadable instruction memory.
// Holds the controller state encoding, the default NOP word and the fetch fault check.
package instr_mem_pkg;

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_RUN   = 2'd1,
      ST_LOAD  = 2'd2
   } state_e;

   localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

   // The full address is compared, so high address bits cannot alias into the array.
   function automatic logic fetch_is_fault(input logic [63:0] addr,
                                           input int unsigned off_w,
                                           input int unsigned depth);
      logic [63:0] off_mask;
      off_mask = (64'd1 << off_w) - 64'd1;
      return ((addr & off_mask) != 64'd0) || ((addr >> off_w) >= 64'(depth));
   endfunction

endpackage

// File: rtl/instr_mem_bank.sv
// DEPTH x DATA_W storage array with one write port and one registered read port.
// The read register holds its value whenever no read is issued.
module instr_mem_bank #(
   parameter  int DATA_W = 32,
   parameter  int DEPTH  = 256,
   localparam int IDX_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [IDX_W-1:0]  i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic              i_re,
   input  logic [IDX_W-1:0]  i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rdata;

   // NOTE: the array has no reset so it maps onto block RAM; the controller's clear sweep initialises it instead.
   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      if (i_re) r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/instr_mem_loadable.sv
// Instruction memory with a streaming program-load port, a post-reset clear sweep,
// one-cycle registered fetches and fault flagging for misaligned or out-of-range addresses.
module instr_mem_loadable
   import instr_mem_pkg::*;
#(
   parameter  int                DATA_W   = 32,
   parameter  int                DEPTH    = 256,
   parameter  int                ADDR_W   = 32,
   parameter  logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_DEFAULT),
   localparam int                IDX_W    = $clog2(DEPTH),
   localparam int                OFF_W    = $clog2(DATA_W/8)
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              mem_ready,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic              fetch_valid,
   output logic [DATA_W-1:0] fetch_instr,
   output logic              fetch_fault,
   input  logic              load_en,
   input  logic              load_valid,
   output logic              load_ready,
   input  logic [DATA_W-1:0] load_data,
   output logic [IDX_W:0]    load_count,
   output logic              load_done
);

   state_e            r_state;
   state_e            w_state_next;
   logic [IDX_W-1:0]  r_clear_ptr;
   logic [IDX_W-1:0]  r_load_ptr;
   logic [IDX_W:0]    r_load_count;
   logic              r_load_done;
   logic              r_fetch_valid;
   logic              r_fetch_fault;
   logic              r_show_nop;

   logic              w_we;
   logic [IDX_W-1:0]  w_waddr;
   logic [DATA_W-1:0] w_wdata;
   logic [DATA_W-1:0] w_rdata;
   logic [63:0]       w_addr64;
   logic [IDX_W-1:0]  w_fetch_idx;
   logic              w_fault;
   logic              w_fetch_acc;
   logic              w_load_hs;
   logic              w_load_last;
   logic              w_load_exit;

   assign w_addr64    = 64'(fetch_addr);
   assign w_fetch_idx = IDX_W'(w_addr64 >> OFF_W);
   assign w_fault     = fetch_is_fault(w_addr64, OFF_W, DEPTH);
   assign w_fetch_acc = (r_state == ST_RUN) && fetch_req;
   assign w_load_hs   = (r_state == ST_LOAD) && load_valid;
   assign w_load_last = w_load_hs && (r_load_ptr == IDX_W'(DEPTH - 1));
   assign w_load_exit = (r_state == ST_LOAD) && (w_load_last || !load_en);

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_CLEAR: if (r_clear_ptr == IDX_W'(DEPTH - 1)) w_state_next = ST_RUN;
         ST_RUN:   if (load_en) w_state_next = ST_LOAD;
         ST_LOAD:  if (w_load_exit) w_state_next = ST_RUN;
         default:  w_state_next = ST_CLEAR;
      endcase
   end

   // Write mux: the clear sweep and the load stream never overlap because they live in different states.
   always_comb begin
      w_we    = 1'b0;
      w_waddr = '0;
      w_wdata = NOP_WORD;
      if (rst_n) begin
         if (r_state == ST_CLEAR) begin
            w_we    = 1'b1;
            w_waddr = r_clear_ptr;
         end else if (w_load_hs) begin
            w_we    = 1'b1;
            w_waddr = r_load_ptr;
            w_wdata = load_data;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= ST_CLEAR;
         r_clear_ptr   <= '0;
         r_load_ptr    <= '0;
         r_load_count  <= '0;
         r_load_done   <= 1'b0;
         r_fetch_valid <= 1'b0;
         r_fetch_fault <= 1'b0;
         r_show_nop    <= 1'b1;
      end else begin
         r_state <= w_state_next;
         if (r_state == ST_CLEAR) r_clear_ptr <= r_clear_ptr + IDX_W'(1);
         if ((r_state == ST_RUN) && load_en) begin
            r_load_ptr   <= '0;
            r_load_count <= '0;
         end else if (w_load_hs) begin
            r_load_ptr   <= r_load_ptr + IDX_W'(1);
            r_load_count <= r_load_count + (IDX_W+1)'(1);
         end
         r_load_done   <= w_load_exit;
         r_fetch_valid <= w_fetch_acc;
         if (w_fetch_acc) begin
            r_fetch_fault <= w_fault;
            r_show_nop    <= w_fault;
         end
      end
   end

   instr_mem_bank #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_bank (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (w_wdata),
      .i_re    (w_fetch_acc),
      .i_raddr (w_fetch_idx),
      .o_rdata (w_rdata)
   );

   assign mem_ready   = (r_state == ST_RUN);
   assign load_ready  = (r_state == ST_LOAD);
   assign fetch_valid = r_fetch_valid;
   assign fetch_fault = r_fetch_fault;
   assign fetch_instr = r_show_nop ? NOP_WORD : w_rdata;
   assign load_count  = r_load_count;
   assign load_done   = r_load_done;

endmodule
